// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch-ratio generator: semitone root table,
// unity ratio in Q1.16 and the request FSM states.
package pitch_pkg;

    localparam int ROOT_W = 17;

    localparam logic [ROOT_W-1:0] UNITY = 17'h1_0000;

    // round(2^(k/12) * 65536), k = 0..11
    localparam logic [ROOT_W-1:0] ROOT_Q16 [0:11] = '{
        17'd65536,  17'd69433,  17'd73562,  17'd77936,
        17'd82570,  17'd87480,  17'd92682,  17'd98193,
        17'd104032, 17'd110218, 17'd116772, 17'd123715
    };

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        SCALE
    } state_t;

endpackage

// File: rtl/semitone_root_rom.sv
// Semitone root ROM: 2^(k/12) in Q1.16 for k = 0..11, indices 12..15 read zero.
module semitone_root_rom
    import pitch_pkg::*;
(
    input  logic [3:0]        idx,
    output logic [ROOT_W-1:0] root
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        root = '0;
        if (idx < 4'd12) root = ROOT_Q16[idx];
    end

endmodule

// File: rtl/pitch_ratio_glide.sv
// Per-channel pitch ratio generator: semitone request -> 2^(semi/12) fixed-point
// target via octave normalisation, ROM lookup and shift; outputs glide to target.
module pitch_ratio_glide
    import pitch_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int DATA_W      = 16,
    parameter  int FRAC_W      = 12,
    parameter  int SEMI_W      = 6,
    parameter  int MAX_SEMI    = 24,
    parameter  int GLIDE_SHIFT = 3,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CH_W-1:0]          req_ch,
    input  logic [SEMI_W-1:0]        req_semi,
    input  logic                     tick,
    output logic                     done,
    output logic                     sat,
    output logic [NUM_CH*DATA_W-1:0] ratio,
    output logic [NUM_CH-1:0]        at_target
);

    localparam int R_W       = SEMI_W + 1;
    localparam int OCT_W     = SEMI_W;
    localparam int SH_W      = 48;
    localparam int PRE_SHIFT = 16 - FRAC_W;

    localparam logic signed [R_W-1:0]   MAX_S   = R_W'(MAX_SEMI);
    localparam logic signed [R_W-1:0]   MIN_S   = -MAX_S;
    localparam logic signed [R_W-1:0]   TWELVE  = R_W'(12);
    localparam logic signed [OCT_W-1:0] OCT_ONE = OCT_W'(1);
    localparam logic [CH_W:0]           NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [DATA_W-1:0]       UNITY_R = DATA_W'(UNITY >> PRE_SHIFT);
    localparam logic [SH_W-1:0]         MAX_R   = SH_W'({DATA_W{1'b1}});

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic signed [R_W-1:0]   r_q, r_d;
    logic signed [OCT_W-1:0] oct_q, oct_d;
    logic                    sat_flag_q, sat_flag_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic                    accept, wr_en, r_in_range;
    logic signed [R_W-1:0]   semi_ext, semi_clamp;
    logic                    semi_clipped;
    logic [ROOT_W-1:0]       base;
    logic signed [OCT_W:0]   net_shift;
    logic [OCT_W:0]          rsh;
    logic [SH_W-1:0]         shifted;
    logic                    ratio_sat;
    logic [DATA_W-1:0]       new_target;

    assign accept       = req_valid & req_ready;
    assign semi_ext     = R_W'($signed(req_semi));
    assign semi_clipped = (semi_ext > MAX_S) || (semi_ext < MIN_S);
    assign semi_clamp   = (semi_ext > MAX_S) ? MAX_S : (semi_ext < MIN_S) ? MIN_S : semi_ext;
    assign r_in_range   = !r_q[R_W-1] && (r_q < TWELVE);

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments only; blocking ones would race other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = NORM;
            NORM:    if (r_in_range) state_d = SCALE;
            SCALE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == IDLE);
    end

    always_comb begin
        ch_d       = ch_q;
        r_d        = r_q;
        oct_d      = oct_q;
        sat_flag_d = sat_flag_q;
        done_d     = 1'b0;
        sat_d      = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                ch_d       = req_ch;
                r_d        = semi_clamp;
                sat_flag_d = semi_clipped;
                oct_d      = '0;
            end
            NORM: if (r_q[R_W-1]) begin
                r_d   = r_q + TWELVE;
                oct_d = oct_q - OCT_ONE;
            end else if (r_q >= TWELVE) begin
                r_d   = r_q - TWELVE;
                oct_d = oct_q + OCT_ONE;
            end
            SCALE: begin
                done_d = 1'b1;
                sat_d  = sat_flag_q | ratio_sat;
                wr_en  = ({1'b0, ch_q} < NUM_CH_W);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q       <= '0;
            r_q        <= '0;
            oct_q      <= '0;
            sat_flag_q <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            r_q        <= r_d;
            oct_q      <= oct_d;
            sat_flag_q <= sat_flag_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
        end
    end

    assign done = done_q;
    assign sat  = sat_q;

    semitone_root_rom u_rom (
        .idx  (r_q[3:0]),
        .root (base)
    );

    // Q1.16 root rescaled to FRAC_W by the octave; right shifts round half up.
    always_comb begin
        net_shift = (OCT_W+1)'(oct_q) - (OCT_W+1)'(PRE_SHIFT);
        rsh       = '0;
        if (!net_shift[OCT_W]) begin
            shifted = SH_W'(base) << net_shift;
        end else begin
            rsh     = -net_shift;
            shifted = (SH_W'(base) + (SH_W'(1) << (rsh - 1))) >> rsh;
        end
    end

    assign ratio_sat  = (shifted > MAX_R);
    assign new_target = ratio_sat ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0]    target_q, target_d;
        logic [DATA_W-1:0]    cur_q, cur_d;
        logic signed [DATA_W:0] diff, step;

        // Glide reads target_q, so a write on the same edge only affects later ticks.
        always_comb begin
            target_d = target_q;
            if (wr_en && (ch_q == CH_W'(g))) target_d = new_target;
            diff = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
            step = diff >>> GLIDE_SHIFT;
            if (step == '0) step = diff[DATA_W] ? '1 : (DATA_W+1)'(1);
            cur_d = cur_q;
            if (tick && (diff != '0)) cur_d = cur_q + step[DATA_W-1:0];
        end

        // NOTE: registers (not RAM) hold the per-channel state, so all of them take the async reset value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                target_q <= UNITY_R;
                cur_q    <= UNITY_R;
            end else begin
                target_q <= target_d;
                cur_q    <= cur_d;
            end
        end

        assign ratio[g*DATA_W +: DATA_W] = cur_q;
        assign at_target[g]              = (cur_q == target_q);
    end

endmodule

// File: tb/tb_pitch_ratio_glide.sv
// Self-checking bench: table of semitone requests with a scoreboard of expected
// ratio/sat/latency, plus hand-written glide, drop, tick-on-write and reset sequences.
module tb_pitch_ratio_glide;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults, GLIDE_SHIFT=0 so a single tick exposes the target.
    logic        a_req_valid = 1'b0, a_req_ready, a_tick = 1'b0, a_done, a_sat;
    logic [0:0]  a_req_ch = '0;
    logic [5:0]  a_req_semi = '0;
    logic [31:0] a_ratio;
    logic [1:0]  a_at_target;

    // Instance B: 3 channels, 14-bit ratio, glide shift 3.
    logic        b_req_valid = 1'b0, b_req_ready, b_tick = 1'b0, b_done, b_sat;
    logic [1:0]  b_req_ch = '0;
    logic [5:0]  b_req_semi = '0;
    logic [41:0] b_ratio;
    logic [2:0]  b_at_target;

    pitch_ratio_glide #(.GLIDE_SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_ch(a_req_ch), .req_semi(a_req_semi), .tick(a_tick), .done(a_done),
        .sat(a_sat), .ratio(a_ratio), .at_target(a_at_target)
    );

    pitch_ratio_glide #(.NUM_CH(3), .DATA_W(14), .GLIDE_SHIFT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_ch(b_req_ch), .req_semi(b_req_semi), .tick(b_tick), .done(b_done),
        .sat(b_sat), .ratio(b_ratio), .at_target(b_at_target)
    );

    typedef struct {
        int          ch;
        int          semi;
        logic [15:0] ratio;
        bit          sat;
        int          lat;
    } vec_t;

    typedef struct {
        int          ch;
        logic [15:0] ratio;
        bit          sat;
        int          lat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input bit is_b, input int ch, input int semi);
        if (is_b) begin
            b_req_valid = 1'b1; b_req_ch = ch[1:0]; b_req_semi = semi[5:0];
        end else begin
            a_req_valid = 1'b1; a_req_ch = ch[0:0]; a_req_semi = semi[5:0];
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_done(input bit is_b, output int cyc);
        cyc = 0;
        while (!(is_b ? b_done : a_done) && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!(is_b ? b_done : a_done)) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles, required within 20", cyc);
        end
    endtask

    task automatic score(input bit is_b, input int cyc, output exp_t e);
        e = '{ch: 0, ratio: 16'h0, sat: 1'b0, lat: 0};
        checks++;
        if ((is_b ? sb_b.size() : sb_a.size()) == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got done with no expected entry");
        end else begin
            e = is_b ? sb_b.pop_front() : sb_a.pop_front();
            check($sformatf("latency_%s_ch%0d", is_b ? "b" : "a", e.ch), cyc, e.lat);
            check($sformatf("sat_%s_ch%0d", is_b ? "b" : "a", e.ch), is_b ? b_sat : a_sat, e.sat);
        end
    endtask

    task automatic pulse_tick(input bit is_b);
        if (is_b) b_tick = 1'b1; else a_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_tick = 1'b0;
        b_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        exp_t e;
        int   cyc, busy, dones, n, prev1, cur0, cur1, mono_bad, last_step;

        vecs[0]  = '{ch: 0, semi:   7, ratio: 16'h17F9, sat: 1'b0, lat: 2};
        vecs[1]  = '{ch: 1, semi:  -1, ratio: 16'h0F1A, sat: 1'b0, lat: 3};
        vecs[2]  = '{ch: 0, semi: -12, ratio: 16'h0800, sat: 1'b0, lat: 3};
        vecs[3]  = '{ch: 1, semi:  12, ratio: 16'h2000, sat: 1'b0, lat: 3};
        vecs[4]  = '{ch: 0, semi:  24, ratio: 16'h4000, sat: 1'b0, lat: 4};
        vecs[5]  = '{ch: 1, semi:  31, ratio: 16'h4000, sat: 1'b1, lat: 4};
        vecs[6]  = '{ch: 0, semi:   0, ratio: 16'h1000, sat: 1'b0, lat: 2};
        vecs[7]  = '{ch: 1, semi: -24, ratio: 16'h0400, sat: 1'b0, lat: 4};
        vecs[8]  = '{ch: 0, semi: -32, ratio: 16'h0400, sat: 1'b1, lat: 4};
        vecs[9]  = '{ch: 1, semi:   5, ratio: 16'h155C, sat: 1'b0, lat: 2};
        vecs[10] = '{ch: 0, semi:  -7, ratio: 16'h0AAE, sat: 1'b0, lat: 3};
        vecs[11] = '{ch: 0, semi:  19, ratio: 16'h2FF2, sat: 1'b0, lat: 3};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready_a", a_req_ready, 1'b1);
        check("reset_done_a", a_done, 1'b0);
        check("reset_ratio_a", a_ratio, 32'h1000_1000);
        check("reset_at_target_a", a_at_target, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ratio_b", b_ratio, {14'h1000, 14'h1000, 14'h1000});
        check("idle_at_target_b", b_at_target, 3'b111);
        check("idle_ready_b", b_req_ready, 1'b1);
        check("idle_sat_b", b_sat, 1'b0);

        // Table-driven conversions on instance A
        for (int i = 0; i < 12; i++) begin
            sb_a.push_back('{ch: vecs[i].ch, ratio: vecs[i].ratio, sat: vecs[i].sat, lat: vecs[i].lat});
            send(1'b0, vecs[i].ch, vecs[i].semi);
            wait_done(1'b0, cyc);
            if (a_done) begin
                score(1'b0, cyc, e);
                pulse_tick(1'b0);
                check($sformatf("done_pulse_len_v%0d", i), a_done, 1'b0);
                check($sformatf("ratio_v%0d_semi%0d", i, vecs[i].semi), a_ratio[e.ch*16 +: 16], e.ratio);
                check($sformatf("at_target_v%0d", i), a_at_target[e.ch], 1'b1);
            end
        end

        // req_valid held while busy: second request waits for req_ready
        a_req_valid = 1'b1; a_req_ch = 1'b1; a_req_semi = 6'd24;
        sb_a.push_back('{ch: 1, ratio: 16'h4000, sat: 1'b0, lat: 4});
        sb_a.push_back('{ch: 1, ratio: 16'h4000, sat: 1'b0, lat: 4});
        @(posedge clk);
        @(negedge clk);
        busy = 0;
        cyc  = 0;
        while (!a_done && cyc < 20) begin
            if (!a_req_ready) busy++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("held_busy_cycles", busy, 4);
        score(1'b0, cyc, e);
        check("held_ready_after_done", a_req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        check("held_second_accepted", a_req_ready, 1'b0);
        wait_done(1'b0, cyc);
        if (a_done) score(1'b0, cyc, e);
        pulse_tick(1'b0);
        check("held_ratio_ch1", a_ratio[31:16], 16'h4000);

        // Out-of-range channel on B: done pulses, nothing changes
        sb_b.push_back('{ch: 3, ratio: 16'h0, sat: 1'b0, lat: 3});
        send(1'b1, 3, 12);
        wait_done(1'b1, cyc);
        if (b_done) score(1'b1, cyc, e);
        pulse_tick(1'b1);
        check("drop_ratio_b", b_ratio, {14'h1000, 14'h1000, 14'h1000});
        check("drop_at_target_b", b_at_target, 3'b111);

        // 14-bit saturation on ch0, then ch1 target 0x2000
        sb_b.push_back('{ch: 0, ratio: 16'h3FFF, sat: 1'b1, lat: 4});
        send(1'b1, 0, 24);
        wait_done(1'b1, cyc);
        if (b_done) score(1'b1, cyc, e);
        sb_b.push_back('{ch: 1, ratio: 16'h2000, sat: 1'b0, lat: 3});
        send(1'b1, 1, 12);
        wait_done(1'b1, cyc);
        if (b_done) score(1'b1, cyc, e);
        check("pre_glide_at_target_b", b_at_target, 3'b100);

        // Glide with shift 3 until every channel settles
        b_tick    = 1'b1;
        prev1     = 32'h1000;
        n         = 0;
        mono_bad  = 0;
        last_step = 0;
        while (b_at_target != 3'b111 && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            cur0 = int'(b_ratio[13:0]);
            cur1 = int'(b_ratio[27:14]);
            if (n == 1) begin
                check("glide_first_step_ch1", cur1, 32'h1200);
                check("glide_first_step_ch0", cur0, 32'h15FF);
            end
            if (cur1 < prev1 || cur1 > 32'h2000) mono_bad++;
            if (cur1 != prev1) last_step = cur1 - prev1;
            prev1 = cur1;
        end
        b_tick = 1'b0;
        check("glide_settled", b_at_target, 3'b111);
        check("glide_monotonic_no_overshoot", mono_bad, 0);
        check("glide_last_step", last_step, 1);
        check("glide_final_ch1", b_ratio[27:14], 14'h2000);
        check("glide_final_ch0", b_ratio[13:0], 14'h3FFF);

        // Tick on the SCALE write edge glides toward the old target
        sb_b.push_back('{ch: 2, ratio: 16'h2000, sat: 1'b0, lat: 3});
        send(1'b1, 2, 12);
        wait_done(1'b1, cyc);
        if (b_done) score(1'b1, cyc, e);
        check("no_tick_ch2_held", b_ratio[41:28], 14'h1000);
        sb_b.push_back('{ch: 2, ratio: 16'h0800, sat: 1'b0, lat: 3});
        send(1'b1, 2, -12);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        b_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_tick = 1'b0;
        check("write_edge_done", b_done, 1'b1);
        if (b_done) score(1'b1, 3, e);
        check("write_edge_old_target", b_ratio[41:28], 14'h1200);
        pulse_tick(1'b1);
        check("after_write_new_target", b_ratio[41:28], 14'h10C0);

        // Reset during NORM abandons the request
        send(1'b0, 0, 24);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", a_req_ready, 1'b1);
        check("midreset_ratio_a", a_ratio, 32'h1000_1000);
        check("midreset_ratio_b", b_ratio, {14'h1000, 14'h1000, 14'h1000});
        @(negedge clk);
        rst_n  = 1'b1;
        a_tick = 1'b1;
        dones  = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (a_done) dones++;
        end
        a_tick = 1'b0;
        check("midreset_no_done", dones, 0);
        check("midreset_ratio_after", a_ratio, 32'h1000_1000);
        check("midreset_at_target", a_at_target, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
